gpr_file: RTL and testbench

//  Architectural integer register file of myCPU: 32 x XLEN GPRs, x0 hardwired to 0.

---
 rtl/cpu_pkg.sv | 12 +
 rtl/gpr_read_port.sv | 30 +++
 rtl/gpr_file.sv | 93 +++++++++
 tb/tb_gpr_file.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared myCPU definitions: register-file geometry and the common index/data types
// used by the pipeline stages that talk to the GPR file.
package cpu_pkg;

  localparam int XLEN      = 64;
  localparam int NR_GPR    = 32;
  localparam int GPR_IDX_W = $clog2(NR_GPR);

  typedef logic [GPR_IDX_W-1:0] gpr_idx_t;
  typedef logic [XLEN-1:0]      xlen_t;

endpackage

// File: rtl/gpr_read_port.sv
// One combinational GPR read port: x0 reads zero, an accepted same-cycle write to the
// addressed register is forwarded when BYPASS is set, otherwise stored state is returned.
module gpr_read_port #(
  parameter int XLEN   = cpu_pkg::XLEN,
  parameter int NR_GPR = cpu_pkg::NR_GPR,
  parameter bit BYPASS = 1'b1
) (
  input  logic [$clog2(NR_GPR)-1:0] i_addr,
  input  logic [NR_GPR*XLEN-1:0]    i_regsFlat,
  input  logic                      i_fwdValid,
  input  logic [$clog2(NR_GPR)-1:0] i_fwdIdx,
  input  logic [XLEN-1:0]           i_fwdData,
  output logic [XLEN-1:0]           o_data
);

  import cpu_pkg::*;

  // Forwarding only ever overrides a non-zero index, so x0 stays hardwired.
  always_comb begin
    o_data = '0;
    if (i_addr != '0) begin
      if (BYPASS && i_fwdValid && (i_fwdIdx == i_addr)) begin
        o_data = i_fwdData;
      end else begin
        o_data = i_regsFlat[i_addr*XLEN +: XLEN];
      end
    end
  end

endmodule

// File: rtl/gpr_file.sv
// Architectural integer register file of myCPU with write-back handshake, two read
// ports for decode, and the snapshot/commit/retire outputs consumed by difftest.
module gpr_file #(
  parameter int XLEN   = cpu_pkg::XLEN,
  parameter int NR_GPR = cpu_pkg::NR_GPR,
  parameter bit BYPASS = 1'b1
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      wb_valid,
  output logic                      wb_ready,
  input  logic                      wb_wen,
  input  logic [$clog2(NR_GPR)-1:0] wb_rd,
  input  logic [XLEN-1:0]           wb_data,
  input  logic [XLEN-1:0]           wb_pc,
  input  logic                      hold,
  input  logic [$clog2(NR_GPR)-1:0] rs1_addr,
  output logic [XLEN-1:0]           rs1_data,
  input  logic [$clog2(NR_GPR)-1:0] rs2_addr,
  output logic [XLEN-1:0]           rs2_data,
  output logic [NR_GPR*XLEN-1:0]    regs_flat,
  output logic                      commit_valid,
  output logic [XLEN-1:0]           commit_pc,
  output logic [63:0]               retire_cnt
);

  import cpu_pkg::*;

  logic [XLEN-1:0]        r_regs [NR_GPR];
  logic                   r_commitValid;
  logic [XLEN-1:0]        r_commitPc;
  logic [63:0]            r_retireCnt;
  logic                   w_accept;
  logic                   w_fwdValid;
  logic [NR_GPR*XLEN-1:0] w_regsFlat;

  // A beat seen during reset is dropped even though ready still tracks hold.
  assign wb_ready   = ~hold;
  assign w_accept   = wb_valid & ~hold & ~reset;
  assign w_fwdValid = w_accept & wb_wen;

  always_comb begin
    w_regsFlat = '0;
    for (int i = 1; i < NR_GPR; i++) begin
      w_regsFlat[i*XLEN +: XLEN] = r_regs[i];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NR_GPR; i++) begin
        r_regs[i] <= '0;
      end
      r_commitValid <= 1'b0;
      r_commitPc    <= '0;
      r_retireCnt   <= '0;
    end else begin
      if (w_fwdValid && (wb_rd != '0)) begin
        r_regs[wb_rd] <= wb_data;
      end
      r_commitValid <= w_accept;
      if (w_accept) begin
        r_commitPc  <= wb_pc;
        r_retireCnt <= r_retireCnt + 64'd1;
      end
    end
  end

  gpr_read_port #(.XLEN(XLEN), .NR_GPR(NR_GPR), .BYPASS(BYPASS)) u_rs1 (
    .i_addr     (rs1_addr),
    .i_regsFlat (w_regsFlat),
    .i_fwdValid (w_fwdValid),
    .i_fwdIdx   (wb_rd),
    .i_fwdData  (wb_data),
    .o_data     (rs1_data)
  );

  gpr_read_port #(.XLEN(XLEN), .NR_GPR(NR_GPR), .BYPASS(BYPASS)) u_rs2 (
    .i_addr     (rs2_addr),
    .i_regsFlat (w_regsFlat),
    .i_fwdValid (w_fwdValid),
    .i_fwdIdx   (wb_rd),
    .i_fwdData  (wb_data),
    .o_data     (rs2_data)
  );

  // Snapshot shows committed state only, so it lines up with commit_valid.
  assign regs_flat    = w_regsFlat;
  assign commit_valid = r_commitValid;
  assign commit_pc    = r_commitPc;
  assign retire_cnt   = r_retireCnt;

endmodule

// File: tb/tb_gpr_file.sv
// Bench for gpr_file: a forwarding and a non-forwarding instance share stimulus and are
// compared against an array-based architectural model of the register file.
module tb_gpr_file;

  logic          clock;
  logic          reset;
  logic          wb_valid;
  logic          wb_wen;
  logic [4:0]    wb_rd;
  logic [63:0]   wb_data;
  logic [63:0]   wb_pc;
  logic          hold;
  logic [4:0]    rs1_addr;
  logic [4:0]    rs2_addr;

  logic          readyB, readyN;
  logic [63:0]   rs1B, rs1N, rs2B, rs2N;
  logic [2047:0] flatB, flatN;
  logic          cvB, cvN;
  logic [63:0]   pcB, pcN, cntB, cntN;

  logic [63:0]   mRegs [32];
  logic          mCv;
  logic [63:0]   mPc;
  logic [63:0]   mCnt;

  int vectors;
  int miscompares;

  gpr_file #(.XLEN(64), .NR_GPR(32), .BYPASS(1'b1)) dutB (
    .clock(clock), .reset(reset), .wb_valid(wb_valid), .wb_ready(readyB),
    .wb_wen(wb_wen), .wb_rd(wb_rd), .wb_data(wb_data), .wb_pc(wb_pc), .hold(hold),
    .rs1_addr(rs1_addr), .rs1_data(rs1B), .rs2_addr(rs2_addr), .rs2_data(rs2B),
    .regs_flat(flatB), .commit_valid(cvB), .commit_pc(pcB), .retire_cnt(cntB)
  );

  gpr_file #(.XLEN(64), .NR_GPR(32), .BYPASS(1'b0)) dutN (
    .clock(clock), .reset(reset), .wb_valid(wb_valid), .wb_ready(readyN),
    .wb_wen(wb_wen), .wb_rd(wb_rd), .wb_data(wb_data), .wb_pc(wb_pc), .hold(hold),
    .rs1_addr(rs1_addr), .rs1_data(rs1N), .rs2_addr(rs2_addr), .rs2_data(rs2N),
    .regs_flat(flatN), .commit_valid(cvN), .commit_pc(pcN), .retire_cnt(cntN)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [63:0] expRead(input logic [4:0] a, input bit byp);
    logic acc;
    acc = wb_valid && !hold && !reset;
    if (a == 5'd0) return 64'd0;
    if (byp && acc && wb_wen && (wb_rd == a)) return wb_data;
    return mRegs[a];
  endfunction

  function automatic logic [2047:0] expFlat();
    logic [2047:0] f;
    f = '0;
    for (int i = 1; i < 32; i++) f[i*64 +: 64] = mRegs[i];
    return f;
  endfunction

  task automatic stepClock();
    logic acc;
    @(posedge clock);
    acc = wb_valid && !hold && !reset;
    if (reset) begin
      for (int i = 0; i < 32; i++) mRegs[i] = 64'd0;
      mCv  = 1'b0;
      mPc  = 64'd0;
      mCnt = 64'd0;
    end else begin
      if (acc && wb_wen && (wb_rd != 5'd0)) mRegs[wb_rd] = wb_data;
      mCv = acc;
      if (acc) begin
        mPc  = wb_pc;
        mCnt = mCnt + 64'd1;
      end
    end
    #1;
  endtask

  task automatic idleInputs();
    wb_valid = 1'b0; wb_wen = 1'b0; wb_rd = 5'd0; wb_data = 64'd0; wb_pc = 64'd0;
    hold = 1'b0; rs1_addr = 5'd0; rs2_addr = 5'd0;
  endtask

  task automatic test_reset();
    idleInputs();
    reset = 1'b1; wb_valid = 1'b1; wb_wen = 1'b1; wb_rd = 5'd3;
    wb_data = {$urandom, $urandom}; wb_pc = 64'h80;
    #1;
    vectors++;
    if (readyB !== 1'b1 || readyN !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL reset_ready got %b/%b want 1", readyB, readyN);
    end
    stepClock();
    stepClock();
    reset = 1'b0;
    idleInputs();
    #1;
    vectors++;
    if (flatB !== '0 || flatN !== '0) begin
      miscompares++;
      $display("[TB] FAIL reset_flat got nonzero, reg3 %h/%h want 0", flatB[3*64 +: 64], flatN[3*64 +: 64]);
    end
    vectors++;
    if (cvB !== 1'b0 || cvN !== 1'b0 || cntB !== 64'd0 || cntN !== 64'd0) begin
      miscompares++;
      $display("[TB] FAIL reset_commit cv %b/%b cnt %0d/%0d want 0", cvB, cvN, cntB, cntN);
    end
  endtask

  task automatic test_write_read();
    wb_valid = 1'b1; wb_wen = 1'b1; wb_rd = 5'd5;
    wb_data = 64'hDEAD_BEEF_0000_0001; wb_pc = 64'h8000_0000;
    stepClock();
    wb_valid = 1'b0; rs1_addr = 5'd5;
    #1;
    vectors++;
    if (rs1B !== 64'hDEAD_BEEF_0000_0001 || rs1N !== 64'hDEAD_BEEF_0000_0001) begin
      miscompares++;
      $display("[TB] FAIL wr_rs1 got %h/%h want %h", rs1B, rs1N, 64'hDEAD_BEEF_0000_0001);
    end
    vectors++;
    if (flatB[5*64 +: 64] !== 64'hDEAD_BEEF_0000_0001 || flatN[5*64 +: 64] !== 64'hDEAD_BEEF_0000_0001) begin
      miscompares++;
      $display("[TB] FAIL wr_flat got %h/%h want %h", flatB[5*64 +: 64], flatN[5*64 +: 64], 64'hDEAD_BEEF_0000_0001);
    end
    vectors++;
    if (cvB !== 1'b1 || pcB !== 64'h8000_0000 || cntB !== 64'd1 || cvN !== 1'b1 || pcN !== 64'h8000_0000 || cntN !== 64'd1) begin
      miscompares++;
      $display("[TB] FAIL wr_commit cv %b pc %h cnt %0d want 1 80000000 1", cvB, pcB, cntB);
    end
  endtask

  task automatic test_x0();
    wb_valid = 1'b1; wb_wen = 1'b1; wb_rd = 5'd0; wb_data = 64'h1234; wb_pc = 64'h8000_0004;
    rs1_addr = 5'd0;
    #1;
    vectors++;
    if (rs1B !== 64'd0 || rs1N !== 64'd0) begin
      miscompares++;
      $display("[TB] FAIL x0_fwd got %h/%h want 0", rs1B, rs1N);
    end
    stepClock();
    wb_valid = 1'b0;
    #1;
    vectors++;
    if (rs1B !== 64'd0 || flatB[63:0] !== 64'd0 || flatN[63:0] !== 64'd0) begin
      miscompares++;
      $display("[TB] FAIL x0_read rs1 %h flat0 %h/%h want 0", rs1B, flatB[63:0], flatN[63:0]);
    end
    vectors++;
    if (cntB !== mCnt || cntN !== mCnt) begin
      miscompares++;
      $display("[TB] FAIL x0_cnt got %0d/%0d want %0d", cntB, cntN, mCnt);
    end
  endtask

  task automatic test_bypass();
    logic [63:0] oldVal;
    oldVal = mRegs[7];
    wb_valid = 1'b1; wb_wen = 1'b1; wb_rd = 5'd7; wb_data = 64'hAA; wb_pc = 64'h8000_0008;
    rs2_addr = 5'd7;
    #1;
    vectors++;
    if (rs2B !== 64'hAA) begin
      miscompares++;
      $display("[TB] FAIL byp_fwd got %h want %h", rs2B, 64'hAA);
    end
    vectors++;
    if (rs2N !== oldVal) begin
      miscompares++;
      $display("[TB] FAIL nobyp_old got %h want %h", rs2N, oldVal);
    end
    vectors++;
    if (flatB[7*64 +: 64] !== oldVal) begin
      miscompares++;
      $display("[TB] FAIL byp_flat_unforwarded got %h want %h", flatB[7*64 +: 64], oldVal);
    end
    stepClock();
    wb_valid = 1'b0;
    #1;
    vectors++;
    if (rs2N !== 64'hAA || rs2B !== 64'hAA) begin
      miscompares++;
      $display("[TB] FAIL byp_next got %h/%h want %h", rs2B, rs2N, 64'hAA);
    end
  endtask

  task automatic test_hold();
    logic [63:0] d;
    d = {$urandom, $urandom};
    hold = 1'b1; wb_valid = 1'b1; wb_wen = 1'b1; wb_rd = 5'd9; wb_data = d; wb_pc = 64'h8000_0100;
    rs1_addr = 5'd9;
    for (int c = 0; c < 3; c++) begin
      #1;
      vectors++;
      if (readyB !== 1'b0 || readyN !== 1'b0 || rs1B !== mRegs[9]) begin
        miscompares++;
        $display("[TB] FAIL hold_ready ready %b/%b rs1 %h want 0 %h", readyB, readyN, rs1B, mRegs[9]);
      end
      stepClock();
      vectors++;
      if (cvB !== 1'b0 || cvN !== 1'b0 || cntB !== mCnt || flatB !== expFlat() || flatN !== expFlat()) begin
        miscompares++;
        $display("[TB] FAIL hold_state cv %b cnt %0d reg9 %h want 0 %0d %h", cvB, cntB, flatB[9*64 +: 64], mCnt, mRegs[9]);
      end
    end
    hold = 1'b0;
    stepClock();
    wb_valid = 1'b0;
    #1;
    vectors++;
    if (cvB !== 1'b1 || cvN !== 1'b1 || flatB[9*64 +: 64] !== d || pcB !== 64'h8000_0100 || cntB !== mCnt) begin
      miscompares++;
      $display("[TB] FAIL hold_release cv %b reg9 %h pc %h cnt %0d want 1 %h 80000100 %0d", cvB, flatB[9*64 +: 64], pcB, cntB, d, mCnt);
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] pcs [4];
    for (int b = 0; b < 4; b++) begin
      pcs[b] = 64'h8000_1000 + 64'(b * 4);
      wb_valid = 1'b1; wb_wen = 1'b1; wb_rd = 5'($urandom_range(1, 31));
      wb_data = {$urandom, $urandom}; wb_pc = pcs[b];
      stepClock();
      vectors++;
      if (cvB !== 1'b1 || cvN !== 1'b1 || pcB !== pcs[b] || pcN !== pcs[b]) begin
        miscompares++;
        $display("[TB] FAIL b2b_commit%0d cv %b/%b pc %h/%h want 1 %h", b, cvB, cvN, pcB, pcN, pcs[b]);
      end
    end
    wb_valid = 1'b0;
    stepClock();
    vectors++;
    if (cvB !== 1'b0 || pcB !== pcs[3] || cntB !== mCnt || flatB !== expFlat()) begin
      miscompares++;
      $display("[TB] FAIL b2b_after cv %b pc %h cnt %0d want 0 %h %0d", cvB, pcB, cntB, pcs[3], mCnt);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 300; c++) begin
      reset    = ($urandom_range(0, 40) == 0);
      wb_valid = $urandom_range(0, 3) != 0;
      hold     = $urandom_range(0, 4) == 0;
      wb_wen   = $urandom_range(0, 3) != 0;
      wb_rd    = 5'($urandom_range(0, 31));
      wb_data  = {$urandom, $urandom};
      wb_pc    = {$urandom, $urandom};
      rs1_addr = ($urandom_range(0, 2) == 0) ? wb_rd : 5'($urandom_range(0, 31));
      rs2_addr = ($urandom_range(0, 2) == 0) ? rs1_addr : 5'($urandom_range(0, 31));
      #1;
      vectors++;
      if (rs1B !== expRead(rs1_addr, 1'b1) || rs2B !== expRead(rs2_addr, 1'b1) ||
          rs1N !== expRead(rs1_addr, 1'b0) || rs2N !== expRead(rs2_addr, 1'b0) ||
          readyB !== ~hold || readyN !== ~hold) begin
        miscompares++;
        $display("[TB] FAIL rand_read%0d rs1 %h/%h want %h/%h rs2 %h/%h want %h/%h", c,
                 rs1B, rs1N, expRead(rs1_addr, 1'b1), expRead(rs1_addr, 1'b0),
                 rs2B, rs2N, expRead(rs2_addr, 1'b1), expRead(rs2_addr, 1'b0));
      end
      stepClock();
      vectors++;
      if (flatB !== expFlat() || flatN !== expFlat() || cvB !== mCv || cvN !== mCv ||
          pcB !== mPc || pcN !== mPc || cntB !== mCnt || cntN !== mCnt) begin
        miscompares++;
        $display("[TB] FAIL rand_state%0d cv %b pc %h cnt %0d want %b %h %0d", c, cvB, pcB, cntB, mCv, mPc, mCnt);
      end
    end
    reset = 1'b0;
    idleInputs();
  endtask

  task automatic test_wrap();
    force dutB.r_retireCnt = 64'hFFFF_FFFF_FFFF_FFFF;
    force dutN.r_retireCnt = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    release dutB.r_retireCnt;
    release dutN.r_retireCnt;
    mCnt = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    vectors++;
    if (cntB !== mCnt || cntN !== mCnt) begin
      miscompares++;
      $display("[TB] FAIL wrap_preset got %h/%h want %h", cntB, cntN, mCnt);
    end
    wb_valid = 1'b1; wb_wen = 1'b0; wb_rd = 5'd4; wb_pc = 64'h8000_2000;
    stepClock();
    wb_valid = 1'b0;
    vectors++;
    if (cntB !== 64'd0 || cntN !== 64'd0 || mCnt !== 64'd0 || cvB !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL wrap_cnt got %h/%h cv %b want 0 1", cntB, cntN, cvB);
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    for (int i = 0; i < 32; i++) mRegs[i] = 64'd0;
    mCv = 1'b0; mPc = 64'd0; mCnt = 64'd0;
    reset = 1'b1;
    idleInputs();
    @(negedge clock);
    test_reset();
    test_write_read();
    test_x0();
    test_bypass();
    test_hold();
    test_back_to_back();
    test_random();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
